// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file and its pending-write
// scoreboard.
//   STACK_POINTER_INIT : reset value of the stack pointer register
//   ZERO               : architectural zero value
//   REG_SP             : index of the stack pointer register
//   PCW_DEFAULT        : default width of a pending-write counter
//   pend_cnt_t         : pending-write counter at the default width
package regfile_scoreboard_pkg;

    localparam logic [31:0] STACK_POINTER_INIT = 32'h0001_0000;
    localparam logic [31:0] ZERO               = 32'h0000_0000;
    localparam logic [4:0]  REG_SP             = 5'd2;
    localparam int          PCW_DEFAULT        = 2;

    typedef logic [PCW_DEFAULT-1:0] pend_cnt_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one register.
//   clk, rst : clock, synchronous active-high reset
//   clr      : drop all pending writes (pipeline flush)
//   inc      : an instruction writing this register was issued
//   dec      : a writeback to this register happened
//   cnt      : current number of outstanding writes
//   err      : overflow/underflow event this cycle (combinational)
module sb_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int PCW = PCW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    input  logic           dec,
    output logic [PCW-1:0] cnt,
    output logic           err
);

    localparam logic [PCW-1:0] CNT_MAX = '1;

    // A simultaneous inc and dec cancel out, so neither end of the range can
    // be violated. A flush discards the whole count, so nothing can be wrong.
    assign err = !clr && ((inc && !dec && (cnt == CNT_MAX)) ||
                          (dec && !inc && (cnt == '0)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass and a per-register
// pending-write scoreboard for RAW hazard detection.
//   clk, rst      : clock, synchronous active-high reset
//   rs_addr_i     : NRD packed read addresses
//   rs_data_o     : NRD packed read data (combinational, bypassed)
//   rs_busy_o     : per-port "producer still outstanding" flag
//   issue_valid_i : decode issues an instruction writing issue_rd_i
//   wb_valid_i    : writeback of wb_data_i to wb_rd_i
//   flush_i       : clear all pending counters
//   err_o         : sticky scoreboard overflow/underflow flag
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int                 DWIDTH  = 32,
    parameter int                 NREGS   = 32,
    parameter int                 NRD     = 2,
    parameter int                 PCW     = PCW_DEFAULT,
    parameter logic [DWIDTH-1:0]  SP_INIT = DWIDTH'(STACK_POINTER_INIT),
    localparam int                AWIDTH  = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AWIDTH-1:0] rs_addr_i,
    output logic [NRD*DWIDTH-1:0] rs_data_o,
    output logic [NRD-1:0]        rs_busy_o,
    input  logic                  issue_valid_i,
    input  logic [AWIDTH-1:0]     issue_rd_i,
    input  logic                  wb_valid_i,
    input  logic [AWIDTH-1:0]     wb_rd_i,
    input  logic [DWIDTH-1:0]     wb_data_i,
    input  logic                  flush_i,
    output logic                  err_o
);

    logic [DWIDTH-1:0] regs    [NREGS];
    logic [PCW-1:0]    cnt     [NREGS];
    logic [NREGS-1:0]  cnt_err;

    // Register 0 is never written after reset, so reading it needs no
    // special case in the read mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == int'(REG_SP)) ? SP_INIT : DWIDTH'(ZERO);
            end
        end else if (wb_valid_i && (wb_rd_i != '0)) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    // Register 0 has no counter: it is permanently not busy.
    assign cnt[0]     = '0;
    assign cnt_err[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter #(
            .PCW (PCW)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (flush_i),
            .inc (issue_valid_i && (issue_rd_i == AWIDTH'(r))),
            .dec (wb_valid_i && (wb_rd_i == AWIDTH'(r))),
            .cnt (cnt[r]),
            .err (cnt_err[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (|cnt_err) begin
            err_o <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AWIDTH-1:0] ra;
        logic              hit;

        assign ra  = rs_addr_i[k*AWIDTH +: AWIDTH];
        assign hit = wb_valid_i && (wb_rd_i == ra) && (ra != '0);

        assign rs_data_o[k*DWIDTH +: DWIDTH] = rst ? '0 : (hit ? wb_data_i : regs[ra]);

        // The last outstanding producer writing back right now clears the
        // hazard in the same cycle, matching the bypassed data.
        assign rs_busy_o[k] = !rst && (cnt[ra] != '0) &&
                              !(hit && (cnt[ra] == PCW'(1)));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int NP = 4;
    localparam int PW = 2;
    localparam int CMAX = (1 << PW) - 1;
    localparam logic [DW-1:0] SP = 32'hCAFE_0100;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*AW-1:0] rs_addr_i;
    logic [NP*DW-1:0] rs_data_o;
    logic [NP-1:0]    rs_busy_o;
    logic             issue_valid_i;
    logic [AW-1:0]    issue_rd_i;
    logic             wb_valid_i;
    logic [AW-1:0]    wb_rd_i;
    logic [DW-1:0]    wb_data_i;
    logic             flush_i;
    logic             err_o;

    regfile_scoreboard #(
        .DWIDTH  (DW),
        .NREGS   (NR),
        .NRD     (NP),
        .PCW     (PW),
        .SP_INIT (SP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs_addr_i     (rs_addr_i),
        .rs_data_o     (rs_data_o),
        .rs_busy_o     (rs_busy_o),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               step;
        logic [NP*DW-1:0] data;
        logic [NP-1:0]    busy;
        logic             err;
        bit               chk_err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    // Reference model: architectural state as plain arrays.
    logic [DW-1:0] mem [NR];
    int            pend [NR];
    logic          merr;
    bit            merr_known = 0;

    // Monitor: the DUT presents a new combinational result every cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < NP; k++) begin
                n_tests++;
                if (rs_data_o[k*DW +: DW] !== e.data[k*DW +: DW]) begin
                    n_fail++;
                    $display("FAIL step %0d rd_data[%0d]: got %h expected %h",
                             e.step, k, rs_data_o[k*DW +: DW], e.data[k*DW +: DW]);
                end
                n_tests++;
                if (rs_busy_o[k] !== e.busy[k]) begin
                    n_fail++;
                    $display("FAIL step %0d rd_busy[%0d]: got %b expected %b",
                             e.step, k, rs_busy_o[k], e.busy[k]);
                end
            end
            if (e.chk_err) begin
                n_tests++;
                if (err_o !== e.err) begin
                    n_fail++;
                    $display("FAIL step %0d err_o: got %b expected %b", e.step, err_o, e.err);
                end
            end
        end
    end

    task automatic step(input bit r, input bit iv, input int ird, input bit wv,
                        input int wrd, input logic [DW-1:0] wd, input bit fl,
                        input int a0, input int a1, input int a2, input int a3);
        int   a [NP];
        exp_t e;
        bit   hit;
        @(posedge clk);
        #1;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        rst           = r;
        issue_valid_i = iv;
        issue_rd_i    = AW'(ird);
        wb_valid_i    = wv;
        wb_rd_i       = AW'(wrd);
        wb_data_i     = wd;
        flush_i       = fl;
        for (int k = 0; k < NP; k++) rs_addr_i[k*AW +: AW] = AW'(a[k]);

        // Expected outputs for this cycle, from the state before the edge.
        step_no++;
        e.step    = step_no;
        e.err     = merr;
        e.chk_err = merr_known;
        for (int k = 0; k < NP; k++) begin
            hit = wv && (wrd == a[k]) && (a[k] != 0);
            if (r) begin
                e.data[k*DW +: DW] = '0;
                e.busy[k]          = 1'b0;
            end else begin
                e.data[k*DW +: DW] = hit ? wd : mem[a[k]];
                e.busy[k]          = (pend[a[k]] != 0) && !(hit && pend[a[k]] == 1);
            end
        end
        q.push_back(e);

        // State after the edge.
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                mem[i]  = '0;
                pend[i] = 0;
            end
            mem[2]     = SP;
            merr       = 1'b0;
            merr_known = 1;
        end else begin
            if (wv && wrd != 0) mem[wrd] = wd;
            if (fl) begin
                for (int i = 0; i < NR; i++) pend[i] = 0;
            end else if (!(iv && wv && ird == wrd)) begin
                if (iv && ird != 0) begin
                    if (pend[ird] == CMAX) merr = 1'b1;
                    else pend[ird]++;
                end
                if (wv && wrd != 0) begin
                    if (pend[wrd] == 0) merr = 1'b1;
                    else pend[wrd]--;
                end
            end
        end
    endtask

    task automatic rd(input int a0, input int a1, input int a2, input int a3);
        step(0, 0, 0, 0, 0, '0, 0, a0, a1, a2, a3);
    endtask

    task automatic issue(input int rdst, input int a0);
        step(0, 1, rdst, 0, 0, '0, 0, a0, 0, 2, 1);
    endtask

    task automatic wb(input int rdst, input logic [DW-1:0] d, input int a0);
        step(0, 0, 0, 1, rdst, d, 0, a0, rdst, 0, 2);
    endtask

    task automatic do_reset();
        step(1, 1, 5, 1, 6, 32'h1111_2222, 0, 2, 5, 6, 0);
    endtask

    initial begin
        rst = 1'b1; issue_valid_i = 1'b0; issue_rd_i = '0; wb_valid_i = 1'b0;
        wb_rd_i = '0; wb_data_i = '0; flush_i = 1'b0; rs_addr_i = '0;
        for (int i = 0; i < NR; i++) begin
            mem[i] = '0;
            pend[i] = 0;
        end
        merr = 1'b0;

        // Reset with competing issue/wb, then read every register.
        do_reset();
        for (int b = 0; b < NR; b += 4) rd(b, b + 1, b + 2, b + 3);

        // Plain write with bypass, then write to r0.
        wb(5, 32'hDEADBEEF, 5);
        rd(5, 5, 0, 2);
        wb(0, 32'h0000_1234, 0);
        rd(0, 5, 0, 0);

        // RAW scoreboard on r7.
        do_reset();
        issue(7, 7);
        rd(7, 7, 0, 0);
        issue(7, 7);
        wb(7, 32'h0000_0011, 7);
        rd(7, 0, 0, 0);
        wb(7, 32'h0000_0055, 7);
        rd(7, 7, 0, 0);

        // Simultaneous issue and wb to r9 with one pending.
        issue(9, 9);
        step(0, 1, 9, 1, 9, 32'h9999_0009, 0, 9, 9, 0, 0);
        rd(9, 9, 9, 9);
        wb(9, 32'h9999_0010, 9);

        // Saturation on r3.
        do_reset();
        for (int i = 0; i < 4; i++) issue(3, 3);
        rd(3, 0, 0, 0);
        for (int i = 0; i < 3; i++) wb(3, 32'h3000_0000 + i, 3);
        rd(3, 0, 0, 0);
        // Net-zero at saturation and at zero: no error.
        do_reset();
        for (int i = 0; i < 3; i++) issue(6, 6);
        step(0, 1, 6, 1, 6, 32'h6666_0006, 0, 6, 0, 0, 0);
        step(0, 1, 8, 1, 8, 32'h8888_0008, 0, 8, 6, 0, 0);
        rd(6, 8, 0, 0);

        // Underflow on r4.
        do_reset();
        wb(4, 32'h4444_4444, 4);
        rd(4, 4, 0, 0);

        // Flush with same-cycle issue and wb.
        do_reset();
        issue(10, 10);
        issue(11, 11);
        step(0, 1, 12, 1, 10, 32'h0000_00A5, 1, 10, 11, 12, 0);
        rd(10, 11, 12, 13);
        rd(12, 10, 11, 2);

        // Randomised traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, NR - 1),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, NR - 1), $urandom,
                 ($urandom_range(0, 39) == 0),
                 $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                 $urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected results left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
